// File: rtl/lon_pkg.sv
// Shared types and helpers for the leading-one normaliser and related
// fixed-to-float blocks.
package lon_pkg;

    // Widest magnitude any user of this package may instantiate.
    localparam int MAG_W_MAX = 128;
    localparam logic [MAG_W_MAX-1:0] MAG_ZERO = '0;

    // Per-stage control record; the data fields (mag, pos) are parameter-sized
    // and therefore live next to this record in the instantiating module.
    typedef struct packed {
        logic valid;
        logic sign;
        logic zero;
    } stage_ctl_t;

    // Width needed to hold a bit index 0..w-1.
    function automatic int pos_width(input int w);
        return (w <= 1) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/prio_enc_hi.sv
// Combinational priority encoder: index of the highest set bit plus a found flag.
// Output index is 0 when no bit is set.
module prio_enc_hi #(
    parameter int WIDTH = 20,
    parameter int POS_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] vec,
    output logic [POS_W-1:0] pos,
    output logic             found
);

    logic [WIDTH-1:0] hot;

    // hot is one-hot: a bit survives only if nothing above it is set.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_hot
            if (gi == WIDTH - 1) begin : g_top
                assign hot[gi] = vec[gi];
            end else begin : g_rest
                assign hot[gi] = vec[gi] & ~(|vec[WIDTH-1:gi+1]);
            end
        end
    endgenerate

    always_comb begin
        pos = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (hot[i]) begin
                pos = pos | POS_W'(i);
            end
        end
    end

    assign found = |vec;

endmodule

// File: rtl/lead_one_norm.sv
// Three-stage leading-one detector and normaliser with valid/ready on both sides.
// S1 takes the magnitude, S2 finds and clamps the leading-one position, S3 shifts.
module lead_one_norm
    import lon_pkg::*;
#(
    parameter int WIDTH     = 20,
    parameter int MIN_POS   = 9,
    parameter bit SIGNED_IN = 1'b1,
    parameter int POS_W     = pos_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [POS_W-1:0] out_pos,
    output logic [WIDTH-1:0] out_norm,
    output logic             out_sign,
    output logic             out_zero
);

    logic             s1_valid_reg;
    logic             s1_sign_reg;
    logic [WIDTH-1:0] s1_mag_reg;

    stage_ctl_t       s2_ctl_reg;
    logic [WIDTH-1:0] s2_mag_reg;
    logic [POS_W-1:0] s2_pos_reg;

    stage_ctl_t       s3_ctl_reg;
    logic [WIDTH-1:0] s3_norm_reg;
    logic [POS_W-1:0] s3_pos_reg;

    logic             s1_load, s2_load, s3_load;
    logic             s1_sign_next;
    logic [WIDTH-1:0] s1_mag_next;
    logic [POS_W-1:0] raw_pos;
    logic             found;
    logic [POS_W-1:0] s2_pos_next;
    logic [POS_W-1:0] shamt;
    logic [WIDTH-1:0] s3_norm_next;

    // A stage takes new contents when it is empty or its successor takes its
    // contents, so bubbles collapse and ready ripples back from out_ready.
    assign s3_load  = ~s3_ctl_reg.valid | out_ready;
    assign s2_load  = ~s2_ctl_reg.valid | s3_load;
    assign s1_load  = ~s1_valid_reg     | s2_load;
    assign in_ready = s1_load;

    // Two's complement of the most negative value wraps to 2^(WIDTH-1),
    // which is still the correct unsigned magnitude.
    assign s1_sign_next = SIGNED_IN & in_data[WIDTH-1];
    assign s1_mag_next  = s1_sign_next ? (~in_data + WIDTH'(1)) : in_data;

    prio_enc_hi #(
        .WIDTH (WIDTH),
        .POS_W (POS_W)
    ) u_prio_enc_hi (
        .vec   (s1_mag_reg),
        .pos   (raw_pos),
        .found (found)
    );

    always_comb begin
        s2_pos_next = raw_pos;
        if (!found || raw_pos < POS_W'(MIN_POS)) begin
            s2_pos_next = POS_W'(MIN_POS);
        end
    end

    // With a clamped position the magnitude has no bits above pos, so the
    // left shift never discards a set bit.
    assign shamt        = POS_W'(WIDTH - 1) - s2_pos_reg;
    assign s3_norm_next = s2_mag_reg << shamt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_reg <= 1'b0;
            s1_sign_reg  <= 1'b0;
            s1_mag_reg   <= MAG_ZERO[WIDTH-1:0];
        end else if (s1_load) begin
            s1_valid_reg <= in_valid;
            if (in_valid) begin
                s1_sign_reg <= s1_sign_next;
                s1_mag_reg  <= s1_mag_next;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_ctl_reg <= '0;
            s2_mag_reg <= MAG_ZERO[WIDTH-1:0];
            s2_pos_reg <= '0;
        end else if (s2_load) begin
            s2_ctl_reg.valid <= s1_valid_reg;
            if (s1_valid_reg) begin
                s2_ctl_reg.sign <= s1_sign_reg;
                s2_ctl_reg.zero <= ~found;
                s2_mag_reg      <= s1_mag_reg;
                s2_pos_reg      <= s2_pos_next;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s3_ctl_reg  <= '0;
            s3_norm_reg <= MAG_ZERO[WIDTH-1:0];
            s3_pos_reg  <= '0;
        end else if (s3_load) begin
            s3_ctl_reg.valid <= s2_ctl_reg.valid;
            if (s2_ctl_reg.valid) begin
                s3_ctl_reg.sign <= s2_ctl_reg.sign;
                s3_ctl_reg.zero <= s2_ctl_reg.zero;
                s3_norm_reg     <= s3_norm_next;
                s3_pos_reg      <= s2_pos_reg;
            end
        end
    end

    assign out_valid = s3_ctl_reg.valid;
    assign out_pos   = s3_pos_reg;
    assign out_norm  = s3_norm_reg;
    assign out_sign  = s3_ctl_reg.sign;
    assign out_zero  = s3_ctl_reg.zero;

endmodule

// File: tb/tb_lead_one_norm.sv
// Directed bench for lead_one_norm: default 20-bit signed instance plus an
// 8-bit unsigned, unclamped instance sharing clock and reset.
module tb_lead_one_norm;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Default instance: WIDTH=20, MIN_POS=9, SIGNED_IN=1
    logic        a_in_valid = 1'b0;
    logic        a_in_ready;
    logic [19:0] a_in_data = '0;
    logic        a_out_valid;
    logic        a_out_ready = 1'b1;
    logic [4:0]  a_out_pos;
    logic [19:0] a_out_norm;
    logic        a_out_sign;
    logic        a_out_zero;

    // Small instance: WIDTH=8, MIN_POS=0, SIGNED_IN=0
    logic        b_in_valid = 1'b0;
    logic        b_in_ready;
    logic [7:0]  b_in_data = '0;
    logic        b_out_valid;
    logic        b_out_ready = 1'b1;
    logic [2:0]  b_out_pos;
    logic [7:0]  b_out_norm;
    logic        b_out_sign;
    logic        b_out_zero;

    int total = 0;
    int passed = 0;

    lead_one_norm dut_a (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .in_data   (a_in_data),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .out_pos   (a_out_pos),
        .out_norm  (a_out_norm),
        .out_sign  (a_out_sign),
        .out_zero  (a_out_zero)
    );

    lead_one_norm #(
        .WIDTH     (8),
        .MIN_POS   (0),
        .SIGNED_IN (1'b0)
    ) dut_b (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_data   (b_in_data),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_pos   (b_out_pos),
        .out_norm  (b_out_norm),
        .out_sign  (b_out_sign),
        .out_zero  (b_out_zero)
    );

    // Drives one sample into dut_a and returns the result plus latency in
    // clock edges counted from the accepting edge (-1 on timeout).
    task automatic run_a(input logic [19:0] d, output logic [4:0] pos, output logic [19:0] norm,
                         output logic sgn, output logic zr, output int lat);
        @(negedge clk);
        a_in_valid = 1'b1;
        a_in_data  = d;
        @(posedge clk);
        #1 a_in_valid = 1'b0;
        lat = 1;
        forever begin
            @(negedge clk);
            if (a_out_valid) break;
            if (lat >= 10) begin
                lat = -1;
                break;
            end
            @(posedge clk);
            lat++;
        end
        pos  = a_out_pos;
        norm = a_out_norm;
        sgn  = a_out_sign;
        zr   = a_out_zero;
    endtask

    task automatic run_b(input logic [7:0] d, output logic [2:0] pos, output logic [7:0] norm,
                         output logic sgn, output logic zr, output int lat);
        @(negedge clk);
        b_in_valid = 1'b1;
        b_in_data  = d;
        @(posedge clk);
        #1 b_in_valid = 1'b0;
        lat = 1;
        forever begin
            @(negedge clk);
            if (b_out_valid) break;
            if (lat >= 10) begin
                lat = -1;
                break;
            end
            @(posedge clk);
            lat++;
        end
        pos  = b_out_pos;
        norm = b_out_norm;
        sgn  = b_out_sign;
        zr   = b_out_zero;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if ({a_out_valid, a_out_pos, a_out_norm, a_out_sign, a_out_zero} !== 28'h0)
            $display("FAIL reset_outputs: got %h expected 0", {a_out_valid, a_out_pos, a_out_norm, a_out_sign, a_out_zero});
        else passed++;
        total++;
        if (b_out_valid !== 1'b0) $display("FAIL reset_b_valid: got %b expected 0", b_out_valid);
        else passed++;
        rst = 1'b0;
        #1;
        total++;
        if (a_in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", a_in_ready);
        else passed++;
        $display("test_reset: outputs cleared, in_ready=%b", a_in_ready);
    endtask

    task automatic test_single_default;
        logic [19:0] vin  [7];
        logic [4:0]  epos [7];
        logic [19:0] enorm[7];
        logic        esgn [7];
        logic        ezr  [7];
        logic [4:0]  pos;
        logic [19:0] norm;
        logic        sgn, zr;
        int          lat;
        vin   = '{20'h00400, 20'hFFFFF, 20'h00000, 20'h80000, 20'h7FFFF, 20'h00200, 20'h00100};
        epos  = '{5'd10,     5'd9,      5'd9,      5'd19,     5'd18,     5'd9,      5'd9};
        enorm = '{20'h80000, 20'h00400, 20'h00000, 20'h80000, 20'hFFFFE, 20'h80000, 20'h40000};
        esgn  = '{1'b0,      1'b1,      1'b0,      1'b1,      1'b0,      1'b0,      1'b0};
        ezr   = '{1'b0,      1'b0,      1'b1,      1'b0,      1'b0,      1'b0,      1'b0};
        for (int i = 0; i < 7; i++) begin
            run_a(vin[i], pos, norm, sgn, zr, lat);
            total++;
            if (lat !== 3) $display("FAIL latency_%0d: got %0d expected 3", i, lat);
            else passed++;
            total++;
            if ({pos, norm, sgn, zr} !== {epos[i], enorm[i], esgn[i], ezr[i]})
                $display("FAIL single_%0d in=%h: got pos=%0d norm=%h sign=%b zero=%b expected pos=%0d norm=%h sign=%b zero=%b",
                         i, vin[i], pos, norm, sgn, zr, epos[i], enorm[i], esgn[i], ezr[i]);
            else passed++;
            $display("single in=%h pos=%0d norm=%h sign=%b zero=%b lat=%0d", vin[i], pos, norm, sgn, zr, lat);
        end
    endtask

    task automatic test_unsigned_small;
        logic [7:0] vin  [3];
        logic [2:0] epos [3];
        logic [7:0] enorm[3];
        logic [2:0] pos;
        logic [7:0] norm;
        logic       sgn, zr;
        int         lat;
        vin   = '{8'h01, 8'hC0, 8'h80};
        epos  = '{3'd0,  3'd7,  3'd7};
        enorm = '{8'h80, 8'hC0, 8'h80};
        for (int i = 0; i < 3; i++) begin
            run_b(vin[i], pos, norm, sgn, zr, lat);
            total++;
            if ({lat == 3, pos, norm, sgn, zr} !== {1'b1, epos[i], enorm[i], 1'b0, 1'b0})
                $display("FAIL small_%0d in=%h: got pos=%0d norm=%h sign=%b zero=%b lat=%0d expected pos=%0d norm=%h sign=0 zero=0 lat=3",
                         i, vin[i], pos, norm, sgn, zr, lat, epos[i], enorm[i]);
            else passed++;
            $display("small in=%h pos=%0d norm=%h sign=%b zero=%b lat=%0d", vin[i], pos, norm, sgn, zr, lat);
        end
    endtask

    task automatic test_back_to_back;
        logic [19:0] vin  [8];
        logic [4:0]  epos [8];
        logic [19:0] enorm[8];
        logic        esgn [8];
        logic        ezr  [8];
        logic [26:0] held;
        logic        held_v;
        bit          started;
        int          sent, recv, cyc, gaps;
        vin   = '{20'h00400, 20'hFFFFF, 20'h00000, 20'h80000, 20'h7FFFF, 20'h00001, 20'hFFC00, 20'h0F000};
        epos  = '{5'd10,     5'd9,      5'd9,      5'd19,     5'd18,     5'd9,      5'd10,     5'd15};
        enorm = '{20'h80000, 20'h00400, 20'h00000, 20'h80000, 20'hFFFFE, 20'h00400, 20'h80000, 20'hF0000};
        esgn  = '{1'b0,      1'b1,      1'b0,      1'b1,      1'b0,      1'b0,      1'b1,      1'b0};
        ezr   = '{1'b0,      1'b0,      1'b1,      1'b0,      1'b0,      1'b0,      1'b0,      1'b0};
        sent = 0; recv = 0; cyc = 0; gaps = 0; held_v = 1'b0; started = 1'b0; held = '0;
        while (recv < 8 && cyc < 60) begin
            @(negedge clk);
            a_out_ready = !(cyc >= 4 && cyc <= 9);
            a_in_valid  = (sent < 8);
            a_in_data   = (sent < 8) ? vin[sent] : 20'h0;
            #1;
            if (cyc == 4) begin
                total++;
                if (a_in_ready !== 1'b0) $display("FAIL stall_in_ready: got %b expected 0", a_in_ready);
                else passed++;
            end
            if (cyc == 10) begin
                total++;
                if (a_in_ready !== 1'b1) $display("FAIL release_in_ready: got %b expected 1", a_in_ready);
                else passed++;
            end
            if (a_out_valid) begin
                started = 1'b1;
                if (!a_out_ready) begin
                    if (held_v) begin
                        total++;
                        if ({a_out_pos, a_out_norm, a_out_sign, a_out_zero} !== held)
                            $display("FAIL stall_hold_c%0d: got %h expected %h", cyc, {a_out_pos, a_out_norm, a_out_sign, a_out_zero}, held);
                        else passed++;
                    end
                    held   = {a_out_pos, a_out_norm, a_out_sign, a_out_zero};
                    held_v = 1'b1;
                end else begin
                    total++;
                    if ({a_out_pos, a_out_norm, a_out_sign, a_out_zero} !== {epos[recv], enorm[recv], esgn[recv], ezr[recv]})
                        $display("FAIL stream_%0d: got pos=%0d norm=%h sign=%b zero=%b expected pos=%0d norm=%h sign=%b zero=%b",
                                 recv, a_out_pos, a_out_norm, a_out_sign, a_out_zero, epos[recv], enorm[recv], esgn[recv], ezr[recv]);
                    else passed++;
                    $display("stream out %0d c%0d pos=%0d norm=%h sign=%b zero=%b", recv, cyc, a_out_pos, a_out_norm, a_out_sign, a_out_zero);
                    recv++;
                    held_v = 1'b0;
                end
            end else if (started) begin
                gaps++;
            end
            if (a_in_valid && a_in_ready) sent++;
            @(posedge clk);
            cyc++;
        end
        #1 a_in_valid = 1'b0;
        a_out_ready = 1'b1;
        total++;
        if (recv !== 8) $display("FAIL stream_count: got %0d expected 8", recv);
        else passed++;
        total++;
        if (gaps !== 0) $display("FAIL stream_gaps: got %0d expected 0", gaps);
        else passed++;
    endtask

    task automatic test_reset_midstream;
        int stale;
        logic [19:0] vin [3];
        vin = '{20'h00400, 20'h80000, 20'h7FFFF};
        a_out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            a_in_valid = 1'b1;
            a_in_data  = vin[i];
            @(posedge clk);
        end
        @(negedge clk);
        a_in_valid = 1'b0;
        #1;
        total++;
        if (a_out_valid !== 1'b1) $display("FAIL inflight_valid: got %b expected 1", a_out_valid);
        else passed++;
        rst = 1'b1;
        #1;
        total++;
        if ({a_out_valid, a_out_pos, a_out_norm, a_out_sign, a_out_zero} !== 28'h0)
            $display("FAIL async_reset: got %h expected 0", {a_out_valid, a_out_pos, a_out_norm, a_out_sign, a_out_zero});
        else passed++;
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++;
        if (a_in_ready !== 1'b1) $display("FAIL post_reset_ready: got %b expected 1", a_in_ready);
        else passed++;
        stale = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (a_out_valid) stale++;
        end
        total++;
        if (stale !== 0) $display("FAIL stale_after_reset: got %0d expected 0", stale);
        else passed++;
        $display("reset midstream: stale results=%0d", stale);
    endtask

    initial begin
        test_reset();
        test_single_default();
        test_unsigned_small();
        test_back_to_back();
        test_reset_midstream();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
